// File: rtl/mips_control_decoder.sv
// mips_control_decoder: combinational opcode/funct decode to a 22-bit control word plus sticky illegal flag
module mips_control_decoder #(
  parameter int CW_W = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic [CW_W-1:0] control_word,
  output logic            illegal_op,
  output logic            illegal_seen
);
  logic [1:0] reg_dst, alu_src_b, wb_sel, hilo_we;
  logic       reg_write, mem_read, mem_write, ill;
  logic [4:0] alu_op;
  logic [2:0] pc_src, mem_mode;
  always_comb begin
    reg_dst   = 2'b00;
    reg_write = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 5'h00;
    pc_src    = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_mode  = 3'b000;
    wb_sel    = 2'b00;
    hilo_we   = 2'b00;
    ill       = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            reg_dst   = 2'b01;
            reg_write = 1'b1;
          end
          default: ;
        endcase
        case (funct)
          6'h20: alu_op = 5'h00;
          6'h21: alu_op = 5'h01;
          6'h22: alu_op = 5'h02;
          6'h23: alu_op = 5'h03;
          6'h24: alu_op = 5'h04;
          6'h25: alu_op = 5'h05;
          6'h26: alu_op = 5'h06;
          6'h27: alu_op = 5'h07;
          6'h2A: alu_op = 5'h08;
          6'h2B: alu_op = 5'h09;
          6'h00: alu_op = 5'h0A;
          6'h02: alu_op = 5'h0B;
          6'h03: alu_op = 5'h0C;
          6'h04: alu_op = 5'h0D;
          6'h06: alu_op = 5'h0E;
          6'h07: alu_op = 5'h0F;
          6'h08: begin alu_op = 5'h15; pc_src = 3'b111; end
          6'h09: begin
            reg_dst = 2'b01; reg_write = 1'b1; alu_op = 5'h15; pc_src = 3'b111; wb_sel = 2'b10;
          end
          6'h10: begin reg_dst = 2'b01; reg_write = 1'b1; alu_op = 5'h16; wb_sel = 2'b11; end
          6'h12: begin reg_dst = 2'b01; reg_write = 1'b1; alu_op = 5'h17; wb_sel = 2'b11; end
          6'h11: begin alu_op = 5'h15; hilo_we = 2'b01; end
          6'h13: begin alu_op = 5'h15; hilo_we = 2'b10; end
          6'h18: begin alu_op = 5'h11; hilo_we = 2'b11; end
          6'h19: begin alu_op = 5'h12; hilo_we = 2'b11; end
          6'h1A: begin alu_op = 5'h13; hilo_we = 2'b11; end
          6'h1B: begin alu_op = 5'h14; hilo_we = 2'b11; end
          default: ill = 1'b1;
        endcase
      end
      6'h01: begin alu_op = 5'h03; pc_src = 3'b101; end
      6'h02: pc_src = 3'b110;
      6'h03: begin reg_dst = 2'b10; reg_write = 1'b1; pc_src = 3'b110; wb_sel = 2'b10; end
      6'h04: begin alu_op = 5'h03; pc_src = 3'b001; end
      6'h05: begin alu_op = 5'h03; pc_src = 3'b010; end
      6'h06: begin alu_op = 5'h03; pc_src = 3'b011; end
      6'h07: begin alu_op = 5'h03; pc_src = 3'b100; end
      6'h08: begin reg_write = 1'b1; alu_src_b = 2'b01; alu_op = 5'h00; end
      6'h09: begin reg_write = 1'b1; alu_src_b = 2'b01; alu_op = 5'h01; end
      6'h0A: begin reg_write = 1'b1; alu_src_b = 2'b01; alu_op = 5'h08; end
      6'h0B: begin reg_write = 1'b1; alu_src_b = 2'b01; alu_op = 5'h09; end
      6'h0C: begin reg_write = 1'b1; alu_src_b = 2'b10; alu_op = 5'h04; end
      6'h0D: begin reg_write = 1'b1; alu_src_b = 2'b10; alu_op = 5'h05; end
      6'h0E: begin reg_write = 1'b1; alu_src_b = 2'b10; alu_op = 5'h06; end
      6'h0F: begin reg_write = 1'b1; alu_src_b = 2'b10; alu_op = 5'h10; end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        reg_write = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 5'h01;
        mem_read  = 1'b1;
        wb_sel    = 2'b01;
        mem_mode  = opcode == 6'h20 ? 3'b011 : opcode == 6'h21 ? 3'b001 :
                    opcode == 6'h22 ? 3'b101 : opcode == 6'h24 ? 3'b100 :
                    opcode == 6'h25 ? 3'b010 : opcode == 6'h26 ? 3'b110 : 3'b000;
      end
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
        alu_src_b = 2'b01;
        alu_op    = 5'h01;
        mem_write = 1'b1;
        mem_mode  = opcode == 6'h28 ? 3'b011 : opcode == 6'h29 ? 3'b001 :
                    opcode == 6'h2A ? 3'b101 : opcode == 6'h2E ? 3'b110 : 3'b000;
      end
      default: ill = 1'b1;
    endcase
  end
  assign illegal_op   = ill;
  assign control_word = ill ? '0 : {reg_dst, reg_write, alu_src_b, alu_op, pc_src,
                                    mem_read, mem_write, mem_mode, wb_sel, hilo_we};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) illegal_seen <= 1'b0;
    else if (ill) illegal_seen <= 1'b1;
endmodule

// File: tb/tb_mips_control_decoder.sv
// tb_mips_control_decoder: directed decode vectors and sticky-flag sequencing
module tb_mips_control_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic [21:0] control_word;
  logic        illegal_op, illegal_seen;
  int          passed = 0, failed = 0, total = 0;
  mips_control_decoder dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .control_word(control_word), .illegal_op(illegal_op), .illegal_seen(illegal_seen)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic dec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic [21:0] cw, input logic il);
    @(negedge clk);
    opcode = op;
    funct  = fn;
    #1;
    chk({tag, "_cw"}, 32'(control_word), 32'(cw));
    chk({tag, "_ill"}, 32'(illegal_op), 32'(il));
  endtask
  initial begin
    rst_n  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h00;
    #1;
    chk("reset_seen", 32'(illegal_seen), 0);
    chk("nop_cw", 32'(control_word), 32'h18A000);
    @(negedge clk);
    rst_n = 1'b1;
    dec("add",   6'h00, 6'h20, 22'h180000, 1'b0);
    dec("lw",    6'h23, 6'h00, 22'h0A1104, 1'b0);
    dec("sw",    6'h2B, 6'h00, 22'h021080, 1'b0);
    dec("beq",   6'h04, 6'h00, 22'h003200, 1'b0);
    dec("jal",   6'h03, 6'h00, 22'h280C08, 1'b0);
    dec("mult",  6'h00, 6'h18, 22'h011003, 1'b0);
    dec("mflo",  6'h00, 6'h12, 22'h19700C, 1'b0);
    dec("bltz",  6'h01, 6'h2A, 22'h003A00, 1'b0);
    dec("addi0", 6'h08, 6'h00, 22'h0A0000, 1'b0);
    dec("addi1", 6'h08, 6'h3F, 22'h0A0000, 1'b0);
    dec("ori",   6'h0D, 6'h12, 22'h0C5000, 1'b0);
    dec("lui",   6'h0F, 6'h00, 22'h0D0000, 1'b0);
    dec("jr",    6'h00, 6'h08, 22'h015E00, 1'b0);
    dec("jalr",  6'h00, 6'h09, 22'h195E08, 1'b0);
    dec("mthi",  6'h00, 6'h11, 22'h015001, 1'b0);
    dec("mtlo",  6'h00, 6'h13, 22'h015002, 1'b0);
    dec("lbu",   6'h24, 6'h00, 22'h0A1144, 1'b0);
    dec("lh",    6'h21, 6'h00, 22'h0A1114, 1'b0);
    dec("swr",   6'h2E, 6'h00, 22'h0210E0, 1'b0);
    dec("srav",  6'h00, 6'h07, 22'h18F000, 1'b0);
    dec("sltu",  6'h00, 6'h2B, 22'h189000, 1'b0);
    dec("bgtz",  6'h07, 6'h00, 22'h003800, 1'b0);
    dec("j",     6'h02, 6'h00, 22'h000C00, 1'b0);
    dec("divu",  6'h00, 6'h1B, 22'h014003, 1'b0);
    dec("nop",   6'h00, 6'h00, 22'h18A000, 1'b0);
    chk("legal_seen", 32'(illegal_seen), 0);
    dec("op2c",  6'h2C, 6'h00, 22'h000000, 1'b1);
    dec("fn01",  6'h00, 6'h01, 22'h000000, 1'b1);
    dec("op3f",  6'h3F, 6'h00, 22'h000000, 1'b1);
    @(posedge clk);
    #1;
    chk("seen_set", 32'(illegal_seen), 1);
    dec("add2",  6'h00, 6'h20, 22'h180000, 1'b0);
    @(posedge clk);
    #1;
    chk("seen_hold", 32'(illegal_seen), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clr", 32'(illegal_seen), 0);
    chk("rst_cw", 32'(control_word), 32'h180000);
    @(negedge clk);
    rst_n = 1'b1;
    dec("fn3f",  6'h00, 6'h3F, 22'h000000, 1'b1);
    @(posedge clk);
    #1;
    chk("seen_fn3f", 32'(illegal_seen), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mips_control_decoder.md
Name: mips_control_decoder

Overview:
- Main instruction decoder for the single-cycle MIPS32 core.
- Maps opcode/funct to a packed 22-bit control word. The word drives register-file, ALU, PC-select, memory and HI/LO datapath controls.
- Decode is purely combinational. The only clocked element is a sticky illegal-instruction flag.

Parameters:
- CW_W, 22, control word width (fixed; other values not supported).

Ports:
- clk  in  1  core clock; used only by the sticky flag.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- control_word  out  22  packed controls, combinational.
- illegal_op  out  1  combinational; 1 when opcode/funct is not supported.
- illegal_seen  out  1  sticky registered flag.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- control_word and illegal_op depend only on opcode/funct. They are independent of clk and rst_n, and valid within the same delta after the inputs change (no latency).
- illegal_seen: cleared to 0 immediately when rst_n=0. Set on a rising clk edge when illegal_op=1. Holds until the next reset.

Control word fields (MSB first); unused fields are 0:
- [21:20] reg_dst: 00 rt, 01 rd, 10 $31.
- [19] reg_write.
- [18:17] alu_src_b: 00 rt, 01 sign-extended imm, 10 zero-extended imm.
- [16:12] alu_op: 00 ADD (overflow-trapping), 01 ADDU, 02 SUB, 03 SUBU, 04 AND, 05 OR, 06 XOR, 07 NOR, 08 SLT, 09 SLTU, 0A SLL (shamt), 0B SRL, 0C SRA, 0D SLLV, 0E SRLV, 0F SRAV, 10 LUI, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 PASS_RS, 16 read HI, 17 read LO.
- [11:9] pc_src: 000 PC+4, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 jump target, 111 jump register.
- [8] mem_read.
- [7] mem_write.
- [6:4] mem_mode: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 101 left (lwl/swl), 110 right (lwr/swr).
- [3:2] wb_sel: 00 ALU, 01 memory, 10 link address, 11 HI/LO.
- [1:0] hilo_we: 00 none, 01 HI, 10 LO, 11 both.

Per-instruction decode:
- R-type ALU ops (add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav): reg_dst=01, reg_write=1, matching alu_op.
- addi/addiu/slti/sltiu: rt, write, src_b=01, alu_op ADD/ADDU/SLT/SLTU.
- andi/ori/xori/lui: rt, write, src_b=10, alu_op AND/OR/XOR/LUI.
- Loads (lb, lh, lwl, lw, lbu, lhu, lwr): rt, write, src_b=01, ADDU, mem_read=1, wb_sel=01, mode per table.
- Stores (sb, sh, swl, sw, swr): src_b=01, ADDU, mem_write=1, mode per table.
- beq/bne/blez/bgtz/bltz: alu_op SUBU, pc_src per table.
- j: pc_src 110.
- jal: reg_dst 10, write, pc_src 110, wb_sel 10.
- jr: PASS_RS, pc_src 111.
- jalr: reg_dst 01, write, PASS_RS, pc_src 111, wb_sel 10.
- mfhi/mflo: rd, write, alu_op 16/17, wb_sel 11.
- mthi/mtlo: PASS_RS, hilo_we 01/10.
- mult/multu/div/divu: matching alu_op, hilo_we 11.

Boundaries:
- opcode 000001 (REGIMM) always decodes as bltz; rt is not an input.
- funct is ignored for all non-SPECIAL opcodes.
- Unsupported opcode, or SPECIAL with unsupported funct: control_word = 0, illegal_op = 1.
- sll with all-zero instruction (nop) is legal.

Test Plan:
- add (op 00, fn 20) -> control_word 0x180000, illegal_op 0.
- lw (op 23) -> 0x0A1104; sw (op 2B) -> 0x021080; beq (op 04) -> 0x003200.
- jal (op 03) -> 0x280C08; mult (op 00, fn 18) -> 0x011003; mflo (op 00, fn 12) -> 0x19700C.
- bltz (op 01), arbitrary funct -> 0x003A00; funct changes do not alter addi (op 08) -> 0x0A0000.
- op 3F, or op 00 with fn 3F -> control_word 0x000000, illegal_op 1; next rising clk sets illegal_seen 1; a following legal op keeps illegal_seen 1.
- rst_n=0 mid-run -> illegal_seen 0 immediately without a clock edge; control_word is unaffected.
